// File: rtl/async_to_sync_mux.sv
// async_to_sync_mux
//
// Merges NUM_CH asynchronous req/ack channels onto one clocked valid/ready
// stream. Each channel uses either the 4-phase (return-to-zero) or the
// 2-phase (transition) protocol, chosen for all channels by PHASE_MODE. A
// round-robin arbiter picks one pending channel per cycle whenever the output
// register is free, and the word is tagged with its source channel.
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high reset
//   async_req      per-channel request, asynchronous to clock
//   async_ack      per-channel acknowledge, registered
//   async_d        channel data; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   sync_valid     output word valid
//   sync_ready     downstream accepts the word when valid & ready
//   sync_d         output data
//   sync_ch        source channel of sync_d
//   async_pending  channel is waiting for a grant (status)
//
// Per-channel states:
//   state       | meaning
//   ST_IDLE     | no request seen; waiting for req_s (4-ph) or req_s != ack (2-ph)
//   ST_PEND     | request seen, waiting for the arbiter to grant the output
//   ST_WAIT_LOW | 4-phase only: word captured, ack high, waiting for req_s low

module async_to_sync_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2,
    parameter int SYNC_STAGE = 2,
    parameter int PHASE_MODE = 0,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            async_req,
    output logic [NUM_CH-1:0]            async_ack,
    input  logic [NUM_CH*DATA_WIDTH-1:0] async_d,
    output logic                         sync_valid,
    input  logic                         sync_ready,
    output logic [DATA_WIDTH-1:0]        sync_d,
    output logic [CH_W-1:0]              sync_ch,
    output logic [NUM_CH-1:0]            async_pending
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PEND     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } ch_state_t;

    logic [SYNC_STAGE-1:0] sync_q  [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
    ch_state_t             state_q [NUM_CH];
    ch_state_t             state_d [NUM_CH];

    logic [NUM_CH-1:0] req_s;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] ack_q;
    logic [NUM_CH-1:0] ack_d;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_found;
    logic              out_free;
    logic              grant;

    // Request synchronizers. Data is deliberately not synchronized: the
    // sender keeps it stable until it sees the ack, and it is only sampled
    // at grant, which is always after req_s has been seen.
    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                sync_q[c] <= '0;
            end else begin
                sync_q[c][0] <= async_req[c];
                for (int k = 1; k < SYNC_STAGE; k++) begin
                    sync_q[c][k] <= sync_q[c][k-1];
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign req_s[c]   = sync_q[c][SYNC_STAGE-1];
        assign pend[c]    = (state_q[c] == ST_PEND);
        assign ch_data[c] = async_d[c*DATA_WIDTH +: DATA_WIDTH];
    end

    // The output register can take a new word when empty or when its
    // current word leaves this cycle, which gives back-to-back throughput.
    assign out_free = !sync_valid || sync_ready;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (int'(last_grant) + 1 + i) % NUM_CH;
            if (!gnt_found && pend[CH_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(cand);
            end
        end
    end

    assign grant = out_free && gnt_found;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
            end
            ack_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
            end
            ack_q <= ack_d;
        end
    end

    always_comb begin
        logic chan_gnt;
        ack_d    = ack_q;
        chan_gnt = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            chan_gnt   = grant && (gnt_idx == CH_W'(c));
            case (state_q[c])
                ST_IDLE: begin
                    // 2-phase: a request is any difference between the
                    // synchronized req level and our own ack level.
                    if ((PHASE_MODE == 0) ? req_s[c] : (req_s[c] != ack_q[c])) begin
                        state_d[c] = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (chan_gnt) begin
                        if (PHASE_MODE == 0) begin
                            state_d[c] = ST_WAIT_LOW;
                            ack_d[c]   = 1'b1;
                        end else begin
                            state_d[c] = ST_IDLE;
                            ack_d[c]   = ~ack_q[c];
                        end
                    end
                end
                ST_WAIT_LOW: begin
                    // A stale high req_s here never re-enters PEND, so one
                    // 4-phase handshake yields exactly one word.
                    if (!req_s[c]) begin
                        state_d[c] = ST_IDLE;
                        ack_d[c]   = 1'b0;
                    end
                end
                default: begin
                    state_d[c] = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_valid <= 1'b0;
            sync_d     <= '0;
            sync_ch    <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (grant) begin
            sync_valid <= 1'b1;
            sync_d     <= ch_data[gnt_idx];
            sync_ch    <= gnt_idx;
            last_grant <= gnt_idx;
        end else if (sync_ready) begin
            sync_valid <= 1'b0;
        end
    end

    assign async_ack     = ack_q;
    assign async_pending = pend;

endmodule

// File: doc/async_to_sync_mux.md
# async_to_sync_mux

Multi-channel successor of the single-channel async-to-sync handshake converter. It accepts NUM_CH independent asynchronous req/ack channels and merges them onto one synchronous valid/ready stream. Each channel runs in a selectable 4-phase (return-to-zero) or 2-phase (transition) protocol. A round-robin arbiter grants pending channels, and the output is tagged with the source channel index. The block sits between asynchronous producers (e.g. UART RX front-ends running on their own timing) and the clocked core.

## Interface
- DATA_WIDTH, 8, width of each channel's data word
- NUM_CH, 2, number of async channels (≥1)
- SYNC_STAGE, 2, synchronizer flops on each req line (≥1; 0 is not supported)
- PHASE_MODE, 0, 0 = 4-phase on all channels, 1 = 2-phase on all channels
- CH_W, derived, max(1, clog2(NUM_CH))

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- async_req  in  NUM_CH  per-channel request, asynchronous to clock
- async_ack  out  NUM_CH  per-channel acknowledge, registered
- async_d  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- sync_valid  out  1  output word valid
- sync_ready  in  1  downstream accepts the word when valid & ready
- sync_d  out  DATA_WIDTH  output data
- sync_ch  out  CH_W  source channel of sync_d
- async_pending  out  NUM_CH  channel is in PEND state (status/debug)

## Operation
- Per channel:
  - async_req passes through a SYNC_STAGE flop chain; req_s is the last stage.
  - async_d is not synchronized. Bundled-data rule: the sender holds async_d stable from before the req event until it sees the ack event. The block samples async_d only at grant, which is after req_s is seen.
- Per-channel FSM, 4-phase (PHASE_MODE=0):
  - IDLE: req_s=1 → PEND.
  - PEND: granted → WAIT_LOW, ack←1.
  - WAIT_LOW: req_s=0 → IDLE, ack←0. Otherwise hold.
- Per-channel FSM, 2-phase (PHASE_MODE=1):
  - IDLE: req_s≠ack → PEND.
  - PEND: granted → IDLE, ack←~ack.
  - No WAIT_LOW state.
- Output register:
  - It is free when !sync_valid, or when sync_valid & sync_ready in the current cycle.
  - When free and at least one channel is in PEND, exactly one channel is granted.
- Arbiter:
  - Round-robin. The search starts at (last_grant+1) mod NUM_CH.
  - last_grant updates on every grant and resets to NUM_CH-1, so channel 0 wins first.
- On grant, at the next edge:
  - sync_valid←1, sync_d←channel data, sync_ch←channel index.
  - The channel's ack event is issued (rise in 4-phase, toggle in 2-phase).
  - The ack means "captured", not "consumed downstream".
- On sync_valid & sync_ready with no grant: sync_valid←0. sync_d and sync_ch hold.
- On simultaneous drain and grant: the new word is loaded and sync_valid stays 1. This gives one word per cycle sustained throughput.
- While the output is not free, pending channels stay in PEND and their acks are withheld. This is how backpressure reaches the senders.

## Timing
- Reset values (all take effect at the edge where reset=1):
  - async_ack=0, sync_valid=0, sync_d=0, sync_ch=0, async_pending=0.
  - All synchronizer flops 0, all FSMs IDLE, last_grant=NUM_CH-1.
- Latency, output free:
  - Take edge 0 as the first edge that samples async_req=1 (4-phase) or the new level (2-phase).
  - req_s is set after edge SYNC_STAGE-1; PEND after edge SYNC_STAGE.
  - sync_valid and the ack event follow edge SYNC_STAGE+1. With SYNC_STAGE=2 this is edge 3.
- 4-phase ack fall: ack falls at the edge after req_s=0 is seen in WAIT_LOW, i.e. SYNC_STAGE+1 edges after async_req falls.
- A new 4-phase transaction is recognised only from IDLE, so a stale high req_s in WAIT_LOW never produces a duplicate word.
- Simultaneous PEND on several channels: one grant per cycle, in round-robin order. A channel that stays pending waits at most NUM_CH-1 grants.
- sync_valid, once high, stays high with sync_d and sync_ch stable until sync_ready=1. Inputs never change the held word.
- Reset mid-transaction:
  - Any captured or pending word is discarded and acks drop to 0.
  - In 2-phase mode the senders must be reset together with the block so their ack reference matches.
  - In 4-phase mode, a req still high after reset is treated as a new request.

## Test plan
- Single-channel 4-phase, SYNC_STAGE=2, ch0 d=0xA5, sync_ready=1:
  - sync_valid high after edge 3 with sync_d=0xA5, sync_ch=0, async_ack[0]=1.
  - Req drop → ack drops 3 edges later.
  - Exactly one word is produced.
- Backpressure: sync_ready=0, ch0 sends 0x11 then ch1 sends 0x22.
  - 0x11 is held. ch1 stays pending with async_ack[1]=0.
  - On sync_ready=1: 0x11 then 0x22 on consecutive cycles, and ack[1] rises with the 0x22 load.
- Round-robin, NUM_CH=4, all four reqs raised together with d=0x10..0x13, sync_ready=1:
  - Outputs are ch0,1,2,3 on four consecutive cycles.
  - Repeat with last_grant=1: order is 2,3,0,1.
- 2-phase mode: ch0 toggles req 0→1→0 with d=0x3C then 0xC3.
  - Two words 0x3C and 0xC3 are output.
  - async_ack[0] toggles 0→1→0.
  - No word is produced while the toggled req is still propagating through the synchronizer.
- Reset mid-operation: assert reset while sync_valid=1 and ch1 is pending.
  - Next cycle: all outputs 0, FSMs IDLE.
  - A 4-phase req still high afterwards yields one fresh word.
